// File: rtl/triroc_sc_loader.sv
// triroc_sc_loader: host-side sequencer for the TRIROC slow-control / probe
// serial chain. Takes the configuration bitstream as a word stream, resets
// the chain, shifts WIDTH bits LSB-first at sys_clk/(2*CLK_DIV), pulses
// load_sc for the slow-control chain and can re-shift the same stream while
// comparing the chain output to confirm its contents.
module triroc_sc_loader #(
  parameter int WIDTH       = 1256,
  parameter int WORD_W      = 32,
  parameter int CLK_DIV     = 10,
  parameter int RSTB_CYCLES = 16,
  localparam int NWORDS     = (WIDTH + WORD_W - 1) / WORD_W,
  localparam int CNT_W      = $clog2(WIDTH + 1)
) (
  input  logic              sys_clk,
  input  logic              sys_reset,
  input  logic              i_start,
  input  logic              i_sel,
  input  logic              i_verify,
  input  logic              i_abort,
  input  logic [WORD_W-1:0] i_word_data,
  input  logic              i_word_valid,
  output logic              o_word_ready,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_err,
  output logic [CNT_W-1:0]  o_mismatch_cnt,
  output logic              o_ck_sr,
  output logic              o_sr_in,
  output logic              o_rstb_sr,
  output logic              o_select,
  output logic              o_load_sc,
  input  logic              i_sr_out
);

  localparam int TMR_MAX = (RSTB_CYCLES > 2 * CLK_DIV) ? RSTB_CYCLES : 2 * CLK_DIV;
  localparam int TMR_W   = $clog2(TMR_MAX + 1);
  localparam int BI_W    = (WORD_W > 1) ? $clog2(WORD_W) : 1;
  localparam int WC_W    = $clog2(NWORDS + 1);

  localparam logic [TMR_W-1:0] DIV_LAST  = TMR_W'(CLK_DIV - 1);
  localparam logic [TMR_W-1:0] RSTB_LAST = TMR_W'(RSTB_CYCLES - 1);
  localparam logic [TMR_W-1:0] LOAD_LAST = TMR_W'(2 * CLK_DIV - 1);
  localparam logic [BI_W-1:0]  BIT_LAST  = BI_W'(WORD_W - 1);
  localparam logic [CNT_W-1:0] WIDTH_C   = CNT_W'(WIDTH);
  localparam logic [CNT_W-1:0] WIDTH_M1  = CNT_W'(WIDTH - 1);
  localparam logic [WC_W-1:0]  NWORDS_C  = WC_W'(NWORDS);

  typedef enum logic [2:0] {
    S_IDLE, S_RSTB, S_SHIFT, S_LOAD, S_VERIFY, S_DONE
  } state_t;

  state_t             state_q, state_d;
  logic               sel_q, sel_d;
  logic               verify_q, verify_d;
  logic               select_q, select_d;
  logic               ck_q, ck_d;
  logic               sr_in_q, sr_in_d;
  logic               rstb_q, rstb_d;
  logic               load_q, load_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               err_q, err_d;
  logic [CNT_W-1:0]   mm_cnt_q, mm_cnt_d;
  logic [TMR_W-1:0]   tmr_q, tmr_d;
  logic               phase_hi_q, phase_hi_d;   // high half of ck_sr period / rstb high tail
  logic               run_q, run_d;             // a ck_sr period is in progress
  logic [CNT_W-1:0]   bit_cnt_q, bit_cnt_d;     // periods started in this pass
  logic [BI_W-1:0]    bit_idx_q, bit_idx_d;     // next bit within the shift word
  logic [WORD_W-1:0]  shift_word_q, shift_word_d;
  logic               shift_valid_q, shift_valid_d;
  logic [WORD_W-1:0]  pf_word_q, pf_word_d;
  logic               pf_valid_q, pf_valid_d;
  logic [WC_W-1:0]    words_acc_q, words_acc_d;
  logic               sync1_q, sync1_d;
  logic               sync2_q, sync2_d;

  logic               ready_window;
  logic               word_ready;
  logic               accept;
  logic               do_start;
  logic               clear_pass;

  // Ready while the prefetch slot is free and this pass still needs words;
  // opens one cycle early (last RSTB cycle) so the first word is waiting.
  always_comb begin
    ready_window = (state_q == S_SHIFT) || (state_q == S_VERIFY) ||
                   ((state_q == S_RSTB) && phase_hi_q && (tmr_q == DIV_LAST));
    word_ready   = ready_window && !pf_valid_q && (words_acc_q < NWORDS_C);
    accept       = word_ready && i_word_valid;
  end

  // Next-state and datapath: sequencing, ck_sr phase timing, word buffering.
  always_comb begin
    state_d       = state_q;
    sel_d         = sel_q;
    verify_d      = verify_q;
    select_d      = select_q;
    ck_d          = ck_q;
    sr_in_d       = sr_in_q;
    rstb_d        = rstb_q;
    load_d        = load_q;
    busy_d        = busy_q;
    done_d        = 1'b0;
    err_d         = err_q;
    mm_cnt_d      = mm_cnt_q;
    tmr_d         = tmr_q;
    phase_hi_d    = phase_hi_q;
    run_d         = run_q;
    bit_cnt_d     = bit_cnt_q;
    bit_idx_d     = bit_idx_q;
    shift_word_d  = shift_word_q;
    shift_valid_d = shift_valid_q;
    pf_word_d     = pf_word_q;
    pf_valid_d    = pf_valid_q;
    words_acc_d   = words_acc_q;
    sync1_d       = i_sr_out;
    sync2_d       = sync1_q;
    do_start      = 1'b0;
    clear_pass    = 1'b0;

    if (accept) begin
      pf_word_d   = i_word_data;
      pf_valid_d  = 1'b1;
      words_acc_d = words_acc_q + 1'b1;
    end

    // Refill the shift word from the prefetch slot as soon as it empties.
    if (((state_q == S_SHIFT) || (state_q == S_VERIFY)) && !shift_valid_q && pf_valid_q) begin
      shift_word_d  = pf_word_q;
      shift_valid_d = 1'b1;
      pf_valid_d    = 1'b0;
    end

    case (state_q)
      S_IDLE: begin
        if (i_start && !i_abort) begin
          state_d    = S_RSTB;
          sel_d      = i_sel;
          verify_d   = i_verify;
          select_d   = i_sel;
          err_d      = 1'b0;
          mm_cnt_d   = '0;
          busy_d     = 1'b1;
          rstb_d     = 1'b0;
          tmr_d      = '0;
          phase_hi_d = 1'b0;
          clear_pass = 1'b1;
        end
      end

      S_RSTB: begin
        if (!phase_hi_q) begin
          if (tmr_q == RSTB_LAST) begin
            rstb_d     = 1'b1;
            tmr_d      = '0;
            phase_hi_d = 1'b1;
          end else begin
            tmr_d = tmr_q + 1'b1;
          end
        end else if (tmr_q == DIV_LAST) begin
          state_d    = S_SHIFT;
          tmr_d      = '0;
          phase_hi_d = 1'b0;
          run_d      = 1'b0;
        end else begin
          tmr_d = tmr_q + 1'b1;
        end
      end

      S_SHIFT, S_VERIFY: begin
        if (!run_q) begin
          // Waiting for data (pass start or underrun): ck_sr held low, timer frozen.
          do_start = shift_valid_q;
        end else if (!phase_hi_q) begin
          if (tmr_q == DIV_LAST) begin
            if ((state_q == S_VERIFY) && (sync2_q != sr_in_q) && (mm_cnt_q != WIDTH_C)) begin
              mm_cnt_d = mm_cnt_q + 1'b1;
            end
            ck_d       = 1'b1;
            phase_hi_d = 1'b1;
            tmr_d      = '0;
          end else begin
            tmr_d = tmr_q + 1'b1;
          end
        end else if (tmr_q == DIV_LAST) begin
          ck_d       = 1'b0;
          tmr_d      = '0;
          phase_hi_d = 1'b0;
          if (bit_cnt_q == WIDTH_C) begin
            run_d = 1'b0;
            if ((state_q == S_SHIFT) && sel_q) begin
              state_d = S_LOAD;
              load_d  = 1'b0;
            end else if ((state_q == S_SHIFT) && verify_q) begin
              state_d    = S_VERIFY;
              clear_pass = 1'b1;
            end else begin
              state_d = S_DONE;
              done_d  = 1'b1;
              busy_d  = 1'b0;
              if (state_q == S_VERIFY) begin
                err_d = (mm_cnt_q != '0);
              end
            end
          end else if (shift_valid_q) begin
            do_start = 1'b1;
          end else begin
            run_d = 1'b0;
          end
        end else begin
          tmr_d = tmr_q + 1'b1;
        end
      end

      S_LOAD: begin
        if (tmr_q == LOAD_LAST) begin
          load_d = 1'b1;
          tmr_d  = '0;
          if (verify_q) begin
            state_d    = S_VERIFY;
            clear_pass = 1'b1;
          end else begin
            state_d = S_DONE;
            done_d  = 1'b1;
            busy_d  = 1'b0;
          end
        end else begin
          tmr_d = tmr_q + 1'b1;
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Begin a ck_sr period: present the next bit together with the falling edge.
    if (do_start) begin
      run_d      = 1'b1;
      tmr_d      = '0;
      phase_hi_d = 1'b0;
      ck_d       = 1'b0;
      sr_in_d    = shift_word_q[bit_idx_q];
      bit_cnt_d  = bit_cnt_q + 1'b1;
      if ((bit_idx_q == BIT_LAST) || (bit_cnt_q == WIDTH_M1)) begin
        shift_valid_d = 1'b0;
        bit_idx_d     = '0;
      end else begin
        bit_idx_d = bit_idx_q + 1'b1;
      end
    end

    if (clear_pass) begin
      words_acc_d   = '0;
      bit_cnt_d     = '0;
      bit_idx_d     = '0;
      shift_valid_d = 1'b0;
      pf_valid_d    = 1'b0;
      run_d         = 1'b0;
    end

    // Abort overrides everything: back to IDLE, chain pins released, buffers dropped.
    if (i_abort && (state_q != S_IDLE)) begin
      state_d       = S_IDLE;
      ck_d          = 1'b0;
      sr_in_d       = 1'b0;
      rstb_d        = 1'b1;
      load_d        = 1'b1;
      busy_d        = 1'b0;
      done_d        = 1'b0;
      run_d         = 1'b0;
      phase_hi_d    = 1'b0;
      tmr_d         = '0;
      shift_valid_d = 1'b0;
      pf_valid_d    = 1'b0;
      words_acc_d   = '0;
    end
  end

  // State and output registers; every chain pin comes straight from a flop.
  always_ff @(posedge sys_clk or negedge sys_reset) begin
    if (!sys_reset) begin
      state_q       <= S_IDLE;
      sel_q         <= 1'b1;
      verify_q      <= 1'b0;
      select_q      <= 1'b1;
      ck_q          <= 1'b0;
      sr_in_q       <= 1'b0;
      rstb_q        <= 1'b1;
      load_q        <= 1'b1;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      err_q         <= 1'b0;
      mm_cnt_q      <= '0;
      tmr_q         <= '0;
      phase_hi_q    <= 1'b0;
      run_q         <= 1'b0;
      bit_cnt_q     <= '0;
      bit_idx_q     <= '0;
      shift_word_q  <= '0;
      shift_valid_q <= 1'b0;
      pf_word_q     <= '0;
      pf_valid_q    <= 1'b0;
      words_acc_q   <= '0;
      sync1_q       <= 1'b0;
      sync2_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      sel_q         <= sel_d;
      verify_q      <= verify_d;
      select_q      <= select_d;
      ck_q          <= ck_d;
      sr_in_q       <= sr_in_d;
      rstb_q        <= rstb_d;
      load_q        <= load_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      err_q         <= err_d;
      mm_cnt_q      <= mm_cnt_d;
      tmr_q         <= tmr_d;
      phase_hi_q    <= phase_hi_d;
      run_q         <= run_d;
      bit_cnt_q     <= bit_cnt_d;
      bit_idx_q     <= bit_idx_d;
      shift_word_q  <= shift_word_d;
      shift_valid_q <= shift_valid_d;
      pf_word_q     <= pf_word_d;
      pf_valid_q    <= pf_valid_d;
      words_acc_q   <= words_acc_d;
      sync1_q       <= sync1_d;
      sync2_q       <= sync2_d;
    end
  end

  assign o_word_ready   = word_ready;
  assign o_busy         = busy_q;
  assign o_done         = done_q;
  assign o_err          = err_q;
  assign o_mismatch_cnt = mm_cnt_q;
  assign o_ck_sr        = ck_q;
  assign o_sr_in        = sr_in_q;
  assign o_rstb_sr      = rstb_q;
  assign o_select       = select_q;
  assign o_load_sc      = load_q;

endmodule

// File: tb/tb_triroc_sc_loader.sv
// tb_triroc_sc_loader: directed bench for triroc_sc_loader with a 40-bit
// chain model, a word feeder and pin-activity counters.
module tb_triroc_sc_loader;

  localparam int WIDTH    = 40;
  localparam int WORD_W   = 16;
  localparam int CNT_W    = 6;
  localparam int GAP_HOLD = 114;
  localparam int TMO      = 3000;

  logic              sys_clk = 1'b0;
  logic              sys_reset;
  logic              i_start, i_sel, i_verify, i_abort;
  logic [WORD_W-1:0] i_word_data;
  logic              i_word_valid;
  logic              o_word_ready, o_busy, o_done, o_err;
  logic [CNT_W-1:0]  o_mismatch_cnt;
  logic              o_ck_sr, o_sr_in, o_rstb_sr, o_select, o_load_sc;
  logic              i_sr_out;

  triroc_sc_loader #(
    .WIDTH(WIDTH), .WORD_W(WORD_W), .CLK_DIV(2), .RSTB_CYCLES(16)
  ) dut (
    .sys_clk(sys_clk), .sys_reset(sys_reset),
    .i_start(i_start), .i_sel(i_sel), .i_verify(i_verify), .i_abort(i_abort),
    .i_word_data(i_word_data), .i_word_valid(i_word_valid), .o_word_ready(o_word_ready),
    .o_busy(o_busy), .o_done(o_done), .o_err(o_err), .o_mismatch_cnt(o_mismatch_cnt),
    .o_ck_sr(o_ck_sr), .o_sr_in(o_sr_in), .o_rstb_sr(o_rstb_sr), .o_select(o_select),
    .o_load_sc(o_load_sc), .i_sr_out(i_sr_out)
  );

  always #5 sys_clk = ~sys_clk;

  logic [WIDTH-1:0] exp_bits = 40'h9A_5678_1234;
  logic [15:0]      words [3] = '{16'h1234, 16'h5678, 16'h009A};

  int total = 0;
  int bad   = 0;

  // controls written by the main sequence
  logic feed_en = 1'b0, gap_en = 1'b0, stuck_en = 1'b0, mon_clr = 1'b0;
  int   acc_base = 0, stuck_edge = 0;

  // monitor state
  logic [WIDTH-1:0] chain = '0;
  logic [WIDTH-1:0] cap = '0;
  int   rise_cnt = 0, rstb_low = 0, load_low = 0, load_fall = 0, done_cyc = 0;
  int   acc_total = 0, sel1_busy = 0, low_run = 0, max_low = 0;
  logic load_prev = 1'b1;
  int   gap_t = 0;

  // snapshots
  int s_rise, s_rstb, s_load_low, s_load_fall, s_done, s_acc, s_sel1;

  // chain: bit k sits at chain[39-k] after a full load, so the output shows bit k before edge k
  assign i_sr_out = chain[WIDTH-1] | (stuck_en && (rise_cnt == stuck_edge));

  always @(posedge o_ck_sr) begin
    rise_cnt <= rise_cnt + 1;
    chain    <= {chain[WIDTH-2:0], o_sr_in};
    cap      <= {o_sr_in, cap[WIDTH-1:1]};
  end

  always @(negedge sys_clk) begin
    if (!o_rstb_sr) rstb_low <= rstb_low + 1;
    if (!o_load_sc) load_low <= load_low + 1;
    if (load_prev && !o_load_sc) load_fall <= load_fall + 1;
    load_prev <= o_load_sc;
    if (o_done) done_cyc <= done_cyc + 1;
    if (i_word_valid && o_word_ready) acc_total <= acc_total + 1;
    if (o_busy && o_select) sel1_busy <= sel1_busy + 1;
    if (mon_clr) begin
      low_run <= 0;
      max_low <= 0;
    end else if (o_busy && !o_ck_sr) begin
      low_run <= low_run + 1;
      if (low_run + 1 > max_low) max_low <= low_run + 1;
    end else begin
      low_run <= 0;
    end
  end

  // word feeder: presents pass-relative word index, optionally starving word 1
  initial begin
    int rel;
    i_word_valid = 1'b0;
    i_word_data  = '0;
    forever begin
      @(posedge sys_clk);
      #1;
      rel = acc_total - acc_base;
      if (!gap_en) gap_t = 0;
      else if (rel == 1) gap_t++;
      if (feed_en && !(gap_en && rel == 1 && gap_t <= GAP_HOLD)) begin
        i_word_valid = 1'b1;
        i_word_data  = words[rel % 3];
      end else begin
        i_word_valid = 1'b0;
      end
    end
  end

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic start_op(input logic sel, input logic ver);
    s_rise = rise_cnt; s_rstb = rstb_low; s_load_low = load_low; s_load_fall = load_fall;
    s_done = done_cyc; s_acc = acc_total; s_sel1 = sel1_busy;
    acc_base = acc_total;
    feed_en  = 1'b1;
    mon_clr  = 1'b1;
    @(negedge sys_clk);
    i_start = 1'b1; i_sel = sel; i_verify = ver;
    @(negedge sys_clk);
    i_start = 1'b0; mon_clr = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    while (o_done !== 1'b1 && n < TMO) begin
      @(negedge sys_clk);
      n++;
    end
    check_val({tag, "_done_seen"}, o_done, 1'b1);
    repeat (3) @(negedge sys_clk);
    feed_en = 1'b0;
    check_val({tag, "_idle_busy"}, o_busy, 1'b0);
    $display("op %s: edges=%0d words=%0d mm=%0d err=%0d", tag, rise_cnt - s_rise,
             acc_total - s_acc, o_mismatch_cnt, o_err);
  endtask

  initial begin
    int n;
    sys_reset = 1'b0; i_start = 1'b0; i_sel = 1'b0; i_verify = 1'b0; i_abort = 1'b0;
    repeat (3) @(negedge sys_clk);
    check_val("rst_ck", o_ck_sr, 1'b0);
    check_val("rst_rstb", o_rstb_sr, 1'b1);
    check_val("rst_select", o_select, 1'b1);
    check_val("rst_load", o_load_sc, 1'b1);
    sys_reset = 1'b1;
    repeat (2) @(negedge sys_clk);
    check_val("rst_busy", o_busy, 1'b0);
    check_val("rst_ready", o_word_ready, 1'b0);
    check_val("rst_done_err", {o_done, o_err}, 2'b00);
    check_val("rst_mm", o_mismatch_cnt, 0);

    // slow control, no verify
    start_op(1'b1, 1'b0);
    wait_done("sc");
    check_val("sc_rstb_low", rstb_low - s_rstb, 16);
    check_val("sc_edges", rise_cnt - s_rise, 40);
    check_val("sc_bits", cap, exp_bits);
    check_val("sc_load_low", load_low - s_load_low, 4);
    check_val("sc_load_pulses", load_fall - s_load_fall, 1);
    check_val("sc_done_cycles", done_cyc - s_done, 1);
    check_val("sc_words", acc_total - s_acc, 3);
    check_val("sc_err", o_err, 1'b0);

    // slow control with verify, ideal chain
    start_op(1'b1, 1'b1);
    wait_done("vfy");
    check_val("vfy_edges", rise_cnt - s_rise, 80);
    check_val("vfy_words", acc_total - s_acc, 6);
    check_val("vfy_mm", o_mismatch_cnt, 0);
    check_val("vfy_err", o_err, 1'b0);
    check_val("vfy_load_pulses", load_fall - s_load_fall, 1);

    // verify with chain bit 7 reading back as 1 (data bit 7 is 0)
    stuck_edge = rise_cnt + 47;
    stuck_en   = 1'b1;
    start_op(1'b1, 1'b1);
    wait_done("stuck");
    stuck_en = 1'b0;
    check_val("stuck_mm", o_mismatch_cnt, 1);
    check_val("stuck_err", o_err, 1'b1);

    // underrun: word 1 withheld well past the word-0/1 boundary
    gap_en = 1'b1;
    start_op(1'b1, 1'b0);
    wait_done("gap");
    gap_en = 1'b0;
    check_val("gap_edges", rise_cnt - s_rise, 40);
    check_val("gap_bits", cap, exp_bits);
    check_val("gap_long_low", max_low >= 40, 1'b1);

    // probe chain, no verify
    start_op(1'b0, 1'b0);
    wait_done("probe");
    check_val("probe_sel_busy", sel1_busy - s_sel1, 0);
    check_val("probe_select", o_select, 1'b0);
    check_val("probe_load_pulses", load_fall - s_load_fall, 0);
    check_val("probe_edges", rise_cnt - s_rise, 40);
    check_val("probe_bits", cap, exp_bits);
    check_val("probe_done_cycles", done_cyc - s_done, 1);

    // abort at bit 20
    start_op(1'b1, 1'b0);
    n = 0;
    while (rise_cnt - s_rise < 20 && n < TMO) begin
      @(negedge sys_clk);
      n++;
    end
    check_val("abort_reach", rise_cnt - s_rise, 20);
    check_val("abort_ck_before", o_ck_sr, 1'b1);
    i_abort = 1'b1;
    @(negedge sys_clk);
    i_abort = 1'b0;
    check_val("abort_ck", o_ck_sr, 1'b0);
    check_val("abort_busy", o_busy, 1'b0);
    feed_en = 1'b0;
    repeat (60) @(negedge sys_clk);
    check_val("abort_no_done", done_cyc - s_done, 0);
    check_val("abort_no_load", load_fall - s_load_fall, 0);
    check_val("abort_rstb", o_rstb_sr, 1'b1);
    $display("op abort: edges=%0d busy=%0d", rise_cnt - s_rise, o_busy);
    start_op(1'b1, 1'b0);
    wait_done("restart");
    check_val("restart_bits", cap, exp_bits);
    check_val("restart_edges", rise_cnt - s_rise, 40);
    check_val("restart_load_pulses", load_fall - s_load_fall, 1);

    // asynchronous reset mid-shift on a high ck_sr with sr_in=1 (bit 9)
    start_op(1'b0, 1'b0);
    n = 0;
    while (!(rise_cnt - s_rise == 10 && o_ck_sr) && n < TMO) begin
      @(negedge sys_clk);
      n++;
    end
    check_val("rst_mid_pins_before", {o_ck_sr, o_sr_in, o_select}, 3'b110);
    #1 sys_reset = 1'b0;
    #1;
    check_val("rst_mid_pins", {o_ck_sr, o_sr_in, o_rstb_sr, o_select, o_load_sc}, 5'b00111);
    check_val("rst_mid_busy", o_busy, 1'b0);
    check_val("rst_mid_ready", o_word_ready, 1'b0);
    feed_en = 1'b0;
    @(negedge sys_clk);
    sys_reset = 1'b1;
    repeat (5) @(negedge sys_clk);
    check_val("rst_mid_stay_idle", {o_busy, o_ck_sr}, 2'b00);
    $display("op reset: edges=%0d", rise_cnt - s_rise);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
